dds_wavegen: RTL and testbench
==============================

DDS_WAVEGEN -- requirements
Module: dds_wavegen

Interface
REQ-001 SHALL have parameter ACC_W, default 24, meaning phase accumulator width; phase index = acc[ACC_W-1:ACC_W-8].
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port enable  input  1  run/hold accumulator.
REQ-005 SHALL have port fcw  input  ACC_W  frequency control word.
REQ-006 SHALL have port fcw_valid  input  1  fcw offered this cycle.
REQ-007 SHALL have port fcw_ready  output  1  fcw accepted when valid&&ready.
REQ-008 SHALL have port wave1_sin  output  8  offset-binary sine sample.
REQ-009 SHALL have port wave1_squ  output  8  square sample.
REQ-010 SHALL have port wave1_tri  output  8  triangle sample.
REQ-011 SHALL have port wave1_saw  output  8  sawtooth sample.
REQ-012 SHALL have port cyc_sync  output  1  one-cycle pulse marking first sample of each period.

Function
REQ-013 SHALL hold states IDLE, RUN, PEND; IDLE when enable=0.
REQ-014 IDLE: acc held; fcw_ready=1; accepted fcw written directly to fcw_active; enable=1 -> RUN.
REQ-015 RUN: acc <= acc + fcw_active each cycle, modulo 2^ACC_W; fcw_ready=1; accepted fcw stored in fcw_pend, -> PEND.
REQ-016 PEND: acc keeps stepping with old fcw_active; fcw_ready=0; on the cycle the accumulator add carries out (wrap), fcw_active <= fcw_pend effective for the next add, -> RUN.
REQ-017 PEND with fcw_active==0 (no wrap possible): fcw_pend SHALL apply on the next cycle, -> RUN.
REQ-018 enable falling in RUN or PEND: -> IDLE next cycle, acc frozen; any fcw_pend applied immediately.
REQ-019 Pipeline: stage 1 registers phase index p; stage 2 registers all four outputs; outputs reflect acc value 2 cycles earlier.
REQ-020 saw = p.
REQ-021 squ = 8'hFF when p<128, else 8'h00.
REQ-022 tri = {p[6:0],1'b0} when p[7]=0, else bitwise-inverse of {p[6:0],1'b0} (p=0->0, 127->254, 128->255, 255->1).
REQ-023 sin = round(128+127*sin(2*pi*p/256)) from 64-entry quarter-wave table: index p[5:0], mirrored (63-p[5:0]) when p[6]=1, result 256-x when p[7]=1; p=0->128, 64->255, 192->1.
REQ-024 cyc_sync SHALL pulse high for one cycle, aligned with the output sample derived from the first acc value after a wrap.
REQ-025 In IDLE, outputs SHALL keep tracking the frozen acc (steady values, no cyc_sync).

Reset
REQ-026 rst SHALL, in the same cycle edge, set acc=0, fcw_active=0, fcw_pend=0, state=IDLE, pipeline regs cleared.
REQ-027 Output reset values: wave1_sin=8'd128, wave1_squ=0, wave1_tri=0, wave1_saw=0, cyc_sync=0, fcw_ready=0 during rst, 1 the cycle after.
REQ-028 rst asserted mid-PEND SHALL discard fcw_pend.

Structure
REQ-029 Shared package SHALL hold the state enumeration, ACC_W default, and the 64-entry quarter-sine constant table.
REQ-030 Sine lookup SHALL be one sub-module, sin_quarter_rom (registered 6-bit address in, 8-bit out, mirror/negate in parent).

Verification
REQ-031 Reset, enable=0 -> sin=128, squ=tri=saw=0, fcw_ready=1 after release.
REQ-032 IDLE load fcw=0x010000, enable=1 -> saw 0,1,2...255,0 one step/cycle, first saw=0 two cycles after enable; cyc_sync every 256 cycles.
REQ-033 Same run: observe sin at saw=0/64/128/192 = 128/255/128/1; tri at saw=127/128 = 254/255; squ toggles at saw=128.
REQ-034 RUN at fcw=0x010000, offer fcw=0x020000 at saw=100 -> fcw_ready drops, step stays 1 until wrap, then saw 0,2,4..., fcw_ready=1, period 128.
REQ-035 fcw=0x000000 running, offer 0x010000 -> applied next cycle, saw begins incrementing.
REQ-036 rst asserted in PEND -> outputs to reset values, pending fcw discarded, saw stays 0 after enable until new fcw loaded.

Source files
------------

// File: rtl/dds_wavegen_pkg.sv
// dds_wavegen_pkg: shared FSM state type, default accumulator width and quarter-wave sine table
package dds_wavegen_pkg;
  localparam int ACC_W_DEF = 24;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PEND} state_t;
  // round(128 + 127*sin(2*pi*i/256)) for i = 0..63
  localparam logic [7:0] SIN_Q [64] = '{
    8'd128, 8'd131, 8'd134, 8'd137, 8'd140, 8'd144, 8'd147, 8'd150,
    8'd153, 8'd156, 8'd159, 8'd162, 8'd165, 8'd168, 8'd171, 8'd174,
    8'd177, 8'd179, 8'd182, 8'd185, 8'd188, 8'd191, 8'd193, 8'd196,
    8'd199, 8'd201, 8'd204, 8'd206, 8'd209, 8'd211, 8'd213, 8'd216,
    8'd218, 8'd220, 8'd222, 8'd224, 8'd226, 8'd228, 8'd230, 8'd232,
    8'd234, 8'd235, 8'd237, 8'd239, 8'd240, 8'd241, 8'd243, 8'd244,
    8'd245, 8'd246, 8'd248, 8'd249, 8'd250, 8'd250, 8'd251, 8'd252,
    8'd253, 8'd253, 8'd254, 8'd254, 8'd254, 8'd255, 8'd255, 8'd255
  };
endpackage

// File: rtl/dds_wavegen_rom.sv
// sin_quarter_rom: quarter-wave sine lookup with a registered 6-bit address
//   clk/rst : clock, synchronous active-high reset (address cleared to 0)
//   i_addr  : quarter-wave index, already mirrored by the parent
//   o_data  : table entry for the address captured on the previous edge
module sin_quarter_rom
  import dds_wavegen_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] i_addr,
  output logic [7:0] o_data
);
  logic [5:0] r_addr;
  always_ff @(posedge clk) r_addr <= rst ? 6'd0 : i_addr;
  assign o_data = SIN_Q[r_addr];
endmodule

// File: rtl/dds_wavegen.sv
// dds_wavegen: DDS phase accumulator with sine/square/triangle/saw outputs
//   clk/rst      : clock, synchronous active-high reset
//   enable       : run (1) or hold (0) the accumulator
//   fcw/_valid   : frequency control word offer; fcw_ready accepts it
//   wave1_*      : 8-bit samples, two cycles behind the accumulator
//   cyc_sync     : one-cycle pulse on the first sample of each period
module dds_wavegen
  import dds_wavegen_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [ACC_W-1:0] fcw,
  input  logic             fcw_valid,
  output logic             fcw_ready,
  output logic [7:0]       wave1_sin,
  output logic [7:0]       wave1_squ,
  output logic [7:0]       wave1_tri,
  output logic [7:0]       wave1_saw,
  output logic             cyc_sync
);
  state_t r_state, w_state_nx;
  logic [ACC_W-1:0] r_acc, r_act, r_pend, w_act_nx, w_pend_nx;
  logic [ACC_W:0] w_sum;
  logic w_carry, w_rdy, w_take, w_step, w_zero;
  logic r_wrap0, r_wrap1;
  logic [7:0] r_p, w_rom;
  logic [5:0] w_addr;
  logic [7:0] r_sin, r_squ, r_tri, r_saw;
  logic r_sync;
  assign w_sum = {1'b0, r_acc} + {1'b0, r_act};
  assign w_carry = w_sum[ACC_W];
  assign w_zero = r_act == '0;
  assign w_rdy = r_state != ST_PEND;
  assign w_take = fcw_valid && w_rdy;
  assign fcw_ready = w_rdy && !rst;
  always_ff @(posedge clk) r_state <= rst ? ST_IDLE : w_state_nx;
  // A pending word waits for the wrap so the current period completes;
  // with a zero step no wrap can come, so it is applied at once.
  always_comb begin
    w_state_nx = r_state;
    w_step = 1'b0;
    w_act_nx = r_act;
    w_pend_nx = r_pend;
    case (r_state)
      ST_IDLE: begin
        w_act_nx = w_take ? fcw : r_act;
        w_state_nx = enable ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        w_step = enable;
        w_act_nx = (w_take && !enable) ? fcw : r_act;
        w_pend_nx = (w_take && enable) ? fcw : r_pend;
        w_state_nx = !enable ? ST_IDLE : w_take ? ST_PEND : ST_RUN;
      end
      ST_PEND: begin
        w_step = enable;
        w_act_nx = (!enable || w_carry || w_zero) ? r_pend : r_act;
        w_state_nx = !enable ? ST_IDLE : (w_carry || w_zero) ? ST_RUN : ST_PEND;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_act <= '0;
      r_pend <= '0;
      r_wrap0 <= 1'b0;
    end else begin
      r_acc <= w_step ? w_sum[ACC_W-1:0] : r_acc;
      r_act <= w_act_nx;
      r_pend <= w_pend_nx;
      r_wrap0 <= w_step && w_carry;
    end
  end
  // The ROM address register sits in stage 1 alongside r_p.
  assign w_addr = r_acc[ACC_W-2] ? ~r_acc[ACC_W-3 -: 6] : r_acc[ACC_W-3 -: 6];
  sin_quarter_rom u_rom (
    .clk    (clk),
    .rst    (rst),
    .i_addr (w_addr),
    .o_data (w_rom)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p <= '0;
      r_wrap1 <= 1'b0;
      r_sin <= 8'd128;
      r_squ <= '0;
      r_tri <= '0;
      r_saw <= '0;
      r_sync <= 1'b0;
    end else begin
      r_p <= r_acc[ACC_W-1 -: 8];
      r_wrap1 <= r_wrap0;
      r_sin <= r_p[7] ? 8'd0 - w_rom : w_rom;
      r_squ <= r_p[7] ? 8'h00 : 8'hFF;
      r_tri <= r_p[7] ? ~{r_p[6:0], 1'b0} : {r_p[6:0], 1'b0};
      r_saw <= r_p;
      r_sync <= r_wrap1;
    end
  end
  assign wave1_sin = r_sin;
  assign wave1_squ = r_squ;
  assign wave1_tri = r_tri;
  assign wave1_saw = r_saw;
  assign cyc_sync = r_sync;
endmodule

// File: tb/tb_dds_wavegen.sv
// tb_dds_wavegen: scoreboard bench for dds_wavegen against an arithmetic reference model
module tb_dds_wavegen;
  localparam int AW = 24;
  localparam longint unsigned MOD = 64'd1 << AW;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, fcw_valid = 1'b0;
  logic [AW-1:0] fcw = '0;
  logic fcw_ready, cyc_sync;
  logic [7:0] wave1_sin, wave1_squ, wave1_tri, wave1_saw;
  dds_wavegen #(.ACC_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .fcw       (fcw),
    .fcw_valid (fcw_valid),
    .fcw_ready (fcw_ready),
    .wave1_sin (wave1_sin),
    .wave1_squ (wave1_squ),
    .wave1_tri (wave1_tri),
    .wave1_saw (wave1_saw),
    .cyc_sync  (cyc_sync)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [7:0] s_sin, s_squ, s_tri, s_saw;
    logic s_sync, s_rdy;
  } exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  int sin_tab[64];
  longint unsigned m_acc, m_act, m_pend;
  bit m_run, m_pnd, m_wrap, off, r_b, en_b, v_b;
  exp_t m_line;
  logic [AW-1:0] f_b;
  function automatic exp_t wave(int p, bit w);
    exp_t e;
    int k, x;
    k = ((p / 64) % 2 == 1) ? 63 - (p % 64) : p % 64;
    x = sin_tab[k];
    e.s_sin = 8'(p >= 128 ? 256 - x : x);
    e.s_squ = p < 128 ? 8'hFF : 8'h00;
    e.s_tri = 8'(p < 128 ? 2 * p : 255 - 2 * (p - 128));
    e.s_saw = 8'(p);
    e.s_sync = w;
    e.s_rdy = 1'b0;
    return e;
  endfunction
  task automatic cyc(input bit r, input bit en, input bit v, input logic [AW-1:0] f);
    exp_t e;
    bit take;
    longint unsigned sum;
    @(negedge clk);
    rst = r;
    enable = en;
    fcw_valid = v;
    fcw = f;
    if (r) begin
      e = '0;
      e.s_sin = 8'd128;
      m_line = wave(0, 1'b0);
      m_acc = 0; m_act = 0; m_pend = 0;
      m_run = 0; m_pnd = 0; m_wrap = 0;
    end else begin
      e = m_line;
      m_line = wave(int'(m_acc >> (AW - 8)), m_wrap);
      take = v && !m_pnd;
      m_wrap = 0;
      if (!m_run) begin
        if (take) m_act = longint'(f);
        m_run = en;
      end else if (!en) begin
        if (m_pnd) m_act = m_pend;
        else if (take) m_act = longint'(f);
        m_run = 0;
        m_pnd = 0;
      end else begin
        sum = m_acc + m_act;
        m_wrap = sum >= MOD;
        m_acc = sum % MOD;
        if (m_pnd) begin
          if (m_wrap || m_act == 0) begin
            m_act = m_pend;
            m_pnd = 0;
          end
        end else if (take) begin
          m_pend = longint'(f);
          m_pnd = 1;
        end
      end
    end
    e.s_rdy = !r && !m_pnd;
    q.push_back(e);
  endtask
  task automatic check_sample();
    exp_t e, a;
    int xs, xt;
    e = q.pop_front();
    a = {wave1_sin, wave1_squ, wave1_tri, wave1_saw, cyc_sync, fcw_ready};
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL sample t=%0t got sin=%0d squ=%0d tri=%0d saw=%0d sync=%0b rdy=%0b expected sin=%0d squ=%0d tri=%0d saw=%0d sync=%0b rdy=%0b",
               $time, a.s_sin, a.s_squ, a.s_tri, a.s_saw, a.s_sync, a.s_rdy,
               e.s_sin, e.s_squ, e.s_tri, e.s_saw, e.s_sync, e.s_rdy);
    end
    xs = (wave1_saw == 8'd0 || wave1_saw == 8'd128) ? 128 : wave1_saw == 8'd64 ? 255 : wave1_saw == 8'd192 ? 1 : -1;
    if (xs >= 0) begin
      n_chk++;
      if (wave1_sin !== 8'(xs)) begin
        n_fail++;
        $display("FAIL sin_point t=%0t saw=%0d got sin=%0d expected %0d", $time, wave1_saw, wave1_sin, xs);
      end
    end
    xt = wave1_saw == 8'd127 ? 254 : wave1_saw == 8'd128 ? 255 : -1;
    if (xt >= 0) begin
      n_chk++;
      if (wave1_tri !== 8'(xt)) begin
        n_fail++;
        $display("FAIL tri_point t=%0t saw=%0d got tri=%0d expected %0d", $time, wave1_saw, wave1_tri, xt);
      end
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) check_sample();
  end
  initial begin
    for (int i = 0; i < 64; i++)
      sin_tab[i] = int'($floor(128.0 + 127.0 * $sin(2.0 * 3.141592653589793 * i / 256.0) + 0.5));
    repeat (3) cyc(1, 0, 0, '0);
    repeat (3) cyc(0, 0, 0, '0);
    cyc(0, 0, 1, 24'h010000);
    repeat (2) cyc(0, 0, 0, '0);
    repeat (300) cyc(0, 1, 0, '0);
    off = 0;
    for (int i = 0; i < 400; i++) begin
      cyc(0, 1, m_pnd || (!off && (m_acc >> 16) == 100), m_pnd ? 24'h0F0000 : 24'h020000);
      if (m_pnd) off = 1;
    end
    repeat (5) cyc(0, 0, 0, '0);
    cyc(0, 0, 1, '0);
    repeat (10) cyc(0, 1, 0, '0);
    cyc(0, 1, 1, 24'h010000);
    repeat (40) cyc(0, 1, 0, '0);
    cyc(0, 1, 1, 24'h030000);
    repeat (3) cyc(0, 1, 0, '0);
    repeat (2) cyc(1, 1, 0, '0);
    repeat (20) cyc(0, 1, 0, '0);
    repeat (2500) begin
      r_b = $urandom_range(0, 199) == 0;
      en_b = $urandom_range(0, 19) != 0;
      v_b = $urandom_range(0, 7) == 0;
      case ($urandom_range(0, 3))
        0: f_b = '0;
        1: f_b = AW'($urandom_range(0, 32'h040000));
        default: f_b = AW'($urandom);
      endcase
      cyc(r_b, en_b, v_b, f_b);
    end
    repeat (2) cyc(0, 0, 0, '0);
    @(posedge clk);
    #2;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending entries expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
